// File: rtl/text_plane.sv
// Character-cell text renderer: COLS x ROWS character RAM with a clear sweep, an external 8x8 font ROM
// and a 3-cycle pixel pipeline. Define CURSOR_EN to add a blinking inverse-video cursor (cursor_addr port).
module text_plane #(
  parameter int         COLS = 80,
  parameter int         ROWS = 30,
  parameter int         ZOOM = 0,
  parameter logic [2:0] FG   = 3'b010,
  parameter logic [2:0] BG   = 3'b000,
  parameter int         AW   = 12
) (
  input  logic          px_clk,
  input  logic          rst_n,
  input  logic [9:0]    x_px,
  input  logic [9:0]    y_px,
  input  logic          activevideo_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          clr,
`ifdef CURSOR_EN
  input  logic [AW-1:0] cursor_addr,
`endif
  output logic          busy,
  output logic [7:0]    font_char,
  output logic [2:0]    font_row,
  input  logic [7:0]    font_data,
  output logic [2:0]    rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          activevideo
);

  localparam int CELLS = COLS * ROWS;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [7:0]    mem [CELLS];
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [9:0]    col, row, xs, ys;
  logic          in_grid, cursor_hit;
  logic [AW-1:0] cell_idx;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  logic [7:0]    font_char_q;
  logic [2:0]    font_row_q, gcol1_q, gcol2_q;
  logic          av1_q, hs1_q, vs1_q, ing1_q, hit1_q;
  logic          av2_q, hs2_q, vs2_q, ing2_q, hit2_q;
  logic [2:0]    rgb_q;
  logic          hs3_q, vs3_q, av3_q;
  logic          pix_bit;

  assign col      = x_px >> (3 + ZOOM);
  assign row      = y_px >> (3 + ZOOM);
  assign xs       = x_px >> ZOOM;
  assign ys       = y_px >> ZOOM;
  assign in_grid  = (int'(col) < COLS) && (int'(row) < ROWS);
  assign cell_idx = AW'(int'(row) * COLS + int'(col));

`ifdef CURSOR_EN
  // Frame counter advances on each falling edge of vsync_in; bit 4 gives a 16-on/16-off blink.
  logic [4:0] frame_q;
  logic       vs_prev_q;

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      frame_q   <= 5'd0;
      vs_prev_q <= 1'b1;
    end else begin
      vs_prev_q <= vsync_in;
      if (vs_prev_q && !vsync_in)
        frame_q <= frame_q + 5'd1;
    end
  end

  assign cursor_hit = in_grid && (cell_idx == cursor_addr) && !frame_q[4];
`else
  assign cursor_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (clr) begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: if (int'(cnt_q) == CELLS - 1) state_d = IDLE;
             else                          cnt_d   = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  // The sweep owns the write port; user writes are dropped while it runs, and reset stops it at once.
  always_comb begin
    we    = 1'b0;
    waddr = wr_addr;
    wdata = wr_data;
    if (state_q == CLEAR) begin
      we    = rst_n;
      waddr = cnt_q;
      wdata = 8'h20;
    end else begin
      we = wr_en && (int'(wr_addr) < CELLS);
    end
  end

  always_ff @(posedge px_clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge px_clk) begin
    if (!rst_n) begin
      font_char_q <= 8'h00;
      font_row_q  <= 3'd0;
      gcol1_q     <= 3'd0;
      av1_q       <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      ing1_q      <= 1'b0;
      hit1_q      <= 1'b0;
      gcol2_q     <= 3'd0;
      av2_q       <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      ing2_q      <= 1'b0;
      hit2_q      <= 1'b0;
      rgb_q       <= 3'b000;
      hs3_q       <= 1'b1;
      vs3_q       <= 1'b1;
      av3_q       <= 1'b0;
    end else begin
      font_char_q <= in_grid ? mem[cell_idx] : 8'h00;
      font_row_q  <= ys[2:0];
      gcol1_q     <= xs[2:0];
      av1_q       <= activevideo_in;
      hs1_q       <= hsync_in;
      vs1_q       <= vsync_in;
      ing1_q      <= in_grid;
      hit1_q      <= cursor_hit;
      gcol2_q     <= gcol1_q;
      av2_q       <= av1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      ing2_q      <= ing1_q;
      hit2_q      <= hit1_q;
      hs3_q       <= hs2_q;
      vs3_q       <= vs2_q;
      av3_q       <= av2_q;
      if (!av2_q)       rgb_q <= 3'b000;
      else if (!ing2_q) rgb_q <= BG;
      else              rgb_q <= pix_bit ? FG : BG;
    end
  end

  // Cursor inversion swaps FG and BG, which is the same as flipping the glyph bit.
  assign pix_bit = font_data[3'd7 - gcol2_q] ^ hit2_q;

  assign busy        = (state_q == CLEAR);
  assign font_char   = font_char_q;
  assign font_row    = font_row_q;
  assign rgb         = rgb_q;
  assign hsync       = hs3_q;
  assign vsync       = vs3_q;
  assign activevideo = av3_q;

endmodule

// File: tb/tb_text_plane.sv
// Randomised bench for text_plane: a behavioural model of the character grid, font and blink
// predicts every pixel, and a 3-deep queue lines predictions up with the registered outputs.
module tb_text_plane;

  localparam int         COLS  = 10;
  localparam int         ROWS  = 4;
  localparam int         ZOOM  = 1;
  localparam int         AW    = 6;
  localparam int         CELLS = COLS * ROWS;
  localparam int         CELL  = 8 << ZOOM;
  localparam logic [2:0] FG    = 3'b110;
  localparam logic [2:0] BG    = 3'b001;

  typedef struct {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       av;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    x_px, y_px;
  logic          av_in, hs_in, vs_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          clr;
  logic          busy;
  logic [7:0]    font_char;
  logic [2:0]    font_row;
  logic [7:0]    font_data;
  logic [2:0]    rgb;
  logic          hsync, vsync, activevideo;
`ifdef CURSOR_EN
  logic [AW-1:0] cursor_addr = AW'(CELLS);
`endif

  int   checks = 0;
  int   errors = 0;
  int   modelMem [CELLS];
  bit   sweeping = 1'b0;
  int   sweepPtr = 0;
  int   modelFrame = 0;
  bit   prevVs = 1'b1;
  exp_t expQ[$];

  always #5 clk = ~clk;

  text_plane #(
    .COLS(COLS), .ROWS(ROWS), .ZOOM(ZOOM), .FG(FG), .BG(BG), .AW(AW)
  ) dut (
    .px_clk(clk),
    .rst_n(rst_n),
    .x_px(x_px),
    .y_px(y_px),
    .activevideo_in(av_in),
    .hsync_in(hs_in),
    .vsync_in(vs_in),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clr(clr),
`ifdef CURSOR_EN
    .cursor_addr(cursor_addr),
`endif
    .busy(busy),
    .font_char(font_char),
    .font_row(font_row),
    .font_data(font_data),
    .rgb(rgb),
    .hsync(hsync),
    .vsync(vsync),
    .activevideo(activevideo)
  );

  // Synthetic font: 'A' row 0 is the classic 8'h18, everything else a scrambled pattern.
  function automatic logic [7:0] fontFn(input logic [7:0] c, input logic [2:0] r);
    if (c == 8'h41 && r == 3'd0) return 8'h18;
    return (c * 8'd13) ^ ({5'd0, r} * 8'd29) ^ 8'h5A;
  endfunction

  always @(posedge clk) font_data <= fontFn(font_char, font_row);

  function automatic logic [2:0] refPixel(input int x, input int y, input logic av);
    int c, r, gr, gc;
    logic [7:0] bits;
    logic bitv;
    if (!av) return 3'b000;
    c = x / CELL;
    r = y / CELL;
    if (c >= COLS || r >= ROWS) return BG;
    gr = (y >> ZOOM) % 8;
    gc = (x >> ZOOM) % 8;
    bits = fontFn(8'(modelMem[r * COLS + c]), 3'(gr));
    bitv = bits[7 - gc];
`ifdef CURSOR_EN
    if (int'(cursor_addr) == r * COLS + c && modelFrame < 16) bitv = ~bitv;
`endif
    return bitv ? FG : BG;
  endfunction

  // One pixel clock: predict the output for the current inputs, then apply this edge's RAM/sweep/frame effects.
  task automatic step();
    exp_t e;
    e.rgb = refPixel(int'(x_px), int'(y_px), av_in);
    e.hs  = hs_in;
    e.vs  = vs_in;
    e.av  = av_in;
    expQ.push_back(e);
    if (sweeping) begin
      if (rst_n) begin
        modelMem[sweepPtr] = 8'h20;
        sweepPtr++;
        if (sweepPtr == CELLS) sweeping = 1'b0;
      end else begin
        sweeping = 1'b0;
      end
    end else begin
      if (wr_en && int'(wr_addr) < CELLS) modelMem[int'(wr_addr)] = int'(wr_data);
      if (clr && rst_n) begin
        sweeping = 1'b1;
        sweepPtr = 0;
      end
    end
    if (!rst_n) begin
      modelFrame = 0;
      prevVs     = 1'b1;
    end else begin
      if (prevVs && !vs_in) modelFrame = (modelFrame + 1) % 32;
      prevVs = vs_in;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
    for (int i = 0; i < 2; i++) begin
      x_px  = 10'($urandom_range(0, 639));
      y_px  = 10'($urandom_range(0, 479));
      av_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
      step();
      checks++;
      if ({rgb, hsync, vsync, activevideo, busy} !== {3'b000, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_outputs actual=%b required=%b", {rgb, hsync, vsync, activevideo, busy}, 7'b0001100);
      end
      checks++;
      if ({font_char, font_row} !== 11'd0) begin
        errors++;
        $display("[TB] FAIL reset_font actual=%h/%0d required=00/0", font_char, font_row);
      end
    end
    rst_n = 1'b1; av_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
    expQ.delete();
  endtask

  task automatic test_clear();
    int n;
    clr = 1'b1;
    step();
    clr = 1'b0;
    n = busy ? 1 : 0;
    for (int k = 0; k < 100 && busy; k++) begin
      if (k == 2) begin
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'h77;
      end
      step();
      wr_en = 1'b0;
      if (busy) n++;
    end
    checks++;
    if (n !== CELLS) begin
      errors++;
      $display("[TB] FAIL clear_busy_cycles actual=%0d required=%0d", n, CELLS);
    end
    for (int idx = 0; idx < CELLS; idx++) begin
      x_px = 10'((idx % COLS) * CELL + 3);
      y_px = 10'((idx / COLS) * CELL + 5);
      av_in = 1'b1;
      step();
      checks++;
      if (font_char !== 8'h20) begin
        errors++;
        $display("[TB] FAIL clear_cell_%0d actual=%h required=20", idx, font_char);
      end
    end
    av_in = 1'b0;
  endtask

  task automatic test_latency();
    exp_t e;
    expQ.delete();
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 2 * CELL + 3; i++) begin
      x_px  = (i < 2 * CELL) ? 10'(i % CELL) : 10'd0;
      y_px  = 10'd0;
      av_in = (i < 2 * CELL) ? 1'(i < CELL) : 1'b0;
      hs_in = (i != 4);
      vs_in = (i != 9);
      step();
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        checks++;
        if ({rgb, hsync, vsync, activevideo} !== {e.rgb, e.hs, e.vs, e.av}) begin
          errors++;
          $display("[TB] FAIL latency_x%0d actual=%b required=%b", i, {rgb, hsync, vsync, activevideo}, {e.rgb, e.hs, e.vs, e.av});
        end
      end
    end
    hs_in = 1'b1; vs_in = 1'b1;
  endtask

  task automatic test_zoom();
    int x, y;
    wr_en = 1'b1; wr_addr = AW'(COLS + 1); wr_data = 8'h42;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = CELL + int'($urandom_range(0, CELL - 1));
      y = CELL + int'($urandom_range(0, CELL - 1));
      x_px = 10'(x); y_px = 10'(y); av_in = 1'b1;
      step();
      checks++;
      if ({font_char, font_row} !== {8'h42, 3'((y / 2) % 8)}) begin
        errors++;
        $display("[TB] FAIL zoom_cell x=%0d y=%0d actual=%h/%0d required=42/%0d", x, y, font_char, font_row, (y / 2) % 8);
      end
    end
    x_px = 10'(2 * CELL + 1); y_px = 10'(CELL + 1);
    step();
    checks++;
    if (font_char !== 8'h20) begin
      errors++;
      $display("[TB] FAIL zoom_neighbour actual=%h required=20", font_char);
    end
    av_in = 1'b0;
  endtask

  task automatic test_out_of_grid();
    exp_t e;
    expQ.delete();
    for (int i = 0; i < 40; i++) begin
      case (i % 3)
        0: begin x_px = 10'($urandom_range(COLS * CELL, 639)); y_px = 10'($urandom_range(0, 479)); av_in = 1'b1; end
        1: begin x_px = 10'($urandom_range(0, COLS * CELL - 1)); y_px = 10'($urandom_range(ROWS * CELL, 479)); av_in = 1'b1; end
        default: begin x_px = 10'($urandom_range(0, COLS * CELL - 1)); y_px = 10'($urandom_range(0, ROWS * CELL - 1)); av_in = 1'b0; end
      endcase
      step();
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        checks++;
        if ({rgb, activevideo} !== {e.rgb, e.av}) begin
          errors++;
          $display("[TB] FAIL out_of_grid_%0d actual=%b required=%b", i, {rgb, activevideo}, {e.rgb, e.av});
        end
      end
    end
    av_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'(8'h60 + i);
      step();
    end
    wr_en = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_busy actual=%b required=0", busy);
    end
    for (int idx = 0; idx < 6; idx++) begin
      x_px = 10'(idx * CELL); y_px = 10'd0; av_in = 1'b1;
      step();
      checks++;
      if (font_char !== ((idx < 3) ? 8'h20 : 8'(8'h60 + idx))) begin
        errors++;
        $display("[TB] FAIL abort_cell_%0d actual=%h required=%h", idx, font_char, (idx < 3) ? 8'h20 : 8'(8'h60 + idx));
      end
    end
    av_in = 1'b0;
    expQ.delete();
  endtask

`ifdef CURSOR_EN
  task automatic test_cursor();
    exp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      cursor_addr = (pass == 0) ? AW'(5) : AW'(CELLS);
      expQ.delete();
      for (int f = 0; f < 34; f++) begin
        for (int i = 0; i < 4; i++) begin
          x_px = 10'(5 * CELL + int'($urandom_range(0, CELL - 1)));
          y_px = 10'($urandom_range(0, CELL - 1));
          av_in = 1'b1;
          vs_in = (i != 3);
          step();
          if (expQ.size() == 3) begin
            e = expQ.pop_front();
            checks++;
            if (rgb !== e.rgb) begin
              errors++;
              $display("[TB] FAIL cursor_p%0d_f%0d actual=%b required=%b", pass, f, rgb, e.rgb);
            end
          end
        end
      end
    end
    vs_in = 1'b1; av_in = 1'b0;
  endtask
`endif

  task automatic test_random();
    exp_t e;
    expQ.delete();
    for (int i = 0; i < 400; i++) begin
      x_px    = 10'($urandom_range(0, COLS * CELL + 40));
      y_px    = 10'($urandom_range(0, ROWS * CELL + 16));
      av_in   = 1'($urandom_range(0, 3) != 0);
      hs_in   = 1'($urandom_range(0, 1));
      vs_in   = 1'($urandom_range(0, 1));
      wr_en   = 1'($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, CELLS + 7));
      wr_data = 8'($urandom);
      clr     = 1'($urandom_range(0, 149) == 0);
      step();
      if (expQ.size() == 3) begin
        e = expQ.pop_front();
        checks++;
        if ({rgb, hsync, vsync, activevideo} !== {e.rgb, e.hs, e.vs, e.av}) begin
          errors++;
          $display("[TB] FAIL random_%0d actual=%b required=%b", i, {rgb, hsync, vsync, activevideo}, {e.rgb, e.hs, e.vs, e.av});
        end
      end
    end
    wr_en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_latency();
    test_zoom();
    test_out_of_grid();
    test_back_to_back();
`ifdef CURSOR_EN
    test_cursor();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
